// File: rtl/arm_dp_pkg.sv
// arm_dp_pkg: shared constants for the ARM data-processing control slice.
// Opcodes, condition codes, control state encoding and NZCV bit positions.
package arm_dp_pkg;

    localparam int DW = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_MI = 4'b0100;
    localparam logic [3:0] CC_PL = 4'b0101;
    localparam logic [3:0] CC_VS = 4'b0110;
    localparam logic [3:0] CC_VC = 4'b0111;
    localparam logic [3:0] CC_HI = 4'b1000;
    localparam logic [3:0] CC_LS = 4'b1001;
    localparam logic [3:0] CC_GE = 4'b1010;
    localparam logic [3:0] CC_LT = 4'b1011;
    localparam logic [3:0] CC_GT = 4'b1100;
    localparam logic [3:0] CC_LE = 4'b1101;
    localparam logic [3:0] CC_AL = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    // Compare/test opcodes: always set flags, never write Rd.
    function automatic logic is_cmp_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

    // Arithmetic opcodes take C and V from the adder.
    function automatic logic is_arith_op(input logic [3:0] op);
        return (op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC,
                           OP_SBC, OP_RSC, OP_CMP, OP_CMN});
    endfunction

endpackage

// File: rtl/arm_cond_check.sv
// arm_cond_check: combinational ARM condition-field evaluator.
// Returns pass=1 when cond holds for the given {N,Z,C,V}.
module arm_cond_check
    import arm_dp_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    // Decode the condition field against the flags.
    always_comb begin
        pass = 1'b0;
        unique case (cond)
            CC_EQ: pass = z;
            CC_NE: pass = !z;
            CC_CS: pass = c;
            CC_CC: pass = !c;
            CC_MI: pass = n;
            CC_PL: pass = !n;
            CC_VS: pass = v;
            CC_VC: pass = !v;
            CC_HI: pass = c && !z;
            CC_LS: pass = !c || z;
            CC_GE: pass = (n == v);
            CC_LT: pass = (n != v);
            CC_GT: pass = !z && (n == v);
            CC_LE: pass = z || (n != v);
            CC_AL: pass = 1'b1;
            CC_NV: pass = 1'b1;
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/arm_dp.sv
// arm_dp_ctrl: IDLE/EXEC/WB sequencer around the data-processing ALU.
// ARM_DP_COND_EN enables the condition evaluator; otherwise all run as AL.
module arm_dp_ctrl
    import arm_dp_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [DATAWIDTH-1:0] in_rn,
    input  logic [DATAWIDTH-1:0] in_op2,
    input  logic                 in_shift_c,
    output logic [DATAWIDTH-1:0] alu_a,
    output logic [DATAWIDTH-1:0] alu_b,
    output logic [3:0]           alu_op,
    output logic                 alu_cin,
    input  logic [DATAWIDTH-1:0] alu_out,
    input  logic                 alu_n,
    input  logic                 alu_z,
    input  logic                 alu_c,
    input  logic                 alu_v,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_rd,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_wr_en,
    output logic                 out_executed,
    output logic [3:0]           nzcv
);

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] a_q, a_d;
    logic [DATAWIDTH-1:0] b_q, b_d;
    logic [3:0]           op_q, op_d;
    logic                 cin_q, cin_d;
    logic [3:0]           rd_q, rd_d;
    logic                 s_q, s_d;
    logic [3:0]           cond_q, cond_d;
    logic                 shc_q, shc_d;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic                 wr_q, wr_d;
    logic                 exec_q, exec_d;
    logic [3:0]           nzcv_q, nzcv_d;
    logic                 pass;
    logic                 unused_instr;

    assign unused_instr = ^{in_instr[27:25], in_instr[19:16],
                            in_instr[11:0]};

`ifdef ARM_DP_COND_EN
    arm_cond_check u_cond (
        .cond (cond_q),
        .nzcv (nzcv_q),
        .pass (pass)
    );
`else
    logic unused_cond;
    assign unused_cond = ^cond_q;
    assign pass = 1'b1;
`endif

    // Next-state and datapath capture for the three-phase sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cin_d   = cin_q;
        rd_d    = rd_q;
        s_d     = s_q;
        cond_d  = cond_q;
        shc_d   = shc_q;
        data_d  = data_q;
        wr_d    = wr_q;
        exec_d  = exec_q;
        nzcv_d  = nzcv_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_rn;
                    b_d     = in_op2;
                    op_d    = in_instr[24:21];
                    s_d     = in_instr[20];
                    rd_d    = in_instr[15:12];
                    cond_d  = in_instr[31:28];
                    shc_d   = in_shift_c;
                    cin_d   = nzcv_q[FLAG_C];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                data_d  = alu_out;
                exec_d  = pass;
                wr_d    = pass && !is_cmp_op(op_q);
                if (pass && (s_q || is_cmp_op(op_q))) begin
                    if (is_arith_op(op_q))
                        nzcv_d = {alu_n, alu_z, alu_c, alu_v};
                    else
                        nzcv_d = {alu_n, alu_z, shc_q,
                                  nzcv_q[FLAG_V]};
                end
                state_d = S_WB;
            end
            S_WB: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cin_q   <= 1'b0;
            rd_q    <= '0;
            s_q     <= 1'b0;
            cond_q  <= '0;
            shc_q   <= 1'b0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            exec_q  <= 1'b0;
            nzcv_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cin_q   <= cin_d;
            rd_q    <= rd_d;
            s_q     <= s_d;
            cond_q  <= cond_d;
            shc_q   <= shc_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            exec_q  <= exec_d;
            nzcv_q  <= nzcv_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_WB);
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_op       = op_q;
    assign alu_cin      = cin_q;
    assign out_rd       = rd_q;
    assign out_data     = data_q;
    assign out_wr_en    = wr_q;
    assign out_executed = exec_q;
    assign nzcv         = nzcv_q;

endmodule
